// File: rtl/rom_read_sequencer.sv
// Sequential ROM reader: walks addresses 0..LAST_ADDRESS, waits the chip access
// time for each one, and hands every captured byte downstream on a valid/ready handshake.
module rom_read_sequencer #(
   parameter int ADDR_WIDTH    = 9,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 4,
   parameter int LAST_ADDRESS  = 511
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  data_ready,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_cs_n,
   output logic                  rom_oe_n,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD, DONE} state_t;

   localparam logic [7:0]            LAST_WAIT = 8'(ACCESS_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LAST_ADDRESS);

   state_t     state;
   logic [7:0] wait_cnt;

   // Address step is ADDR_WIDTH wide; the carry is dropped, and the pass ends before any wrap.
   function automatic logic [ADDR_WIDTH-1:0] next_address(input logic [ADDR_WIDTH-1:0] a);
      return a + ADDR_WIDTH'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         rom_address <= '0;
         rom_cs_n    <= 1'b1;
         rom_oe_n    <= 1'b1;
         data_out    <= '0;
         data_valid  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else if (abort) begin
         // Address and last byte are left as they were so the display keeps its value.
         state      <= IDLE;
         wait_cnt   <= '0;
         rom_cs_n   <= 1'b1;
         rom_oe_n   <= 1'b1;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= WAIT;
                  wait_cnt    <= '0;
                  rom_address <= '0;
                  rom_cs_n    <= 1'b0;
                  rom_oe_n    <= 1'b0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (wait_cnt == LAST_WAIT) begin
                  data_out   <= rom_data;
                  data_valid <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (data_ready) begin
                  data_valid <= 1'b0;
                  if (rom_address == LAST_ADDR) begin
                     rom_cs_n <= 1'b1;
                     rom_oe_n <= 1'b1;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= DONE;
                  end else begin
                     // Strobes stay low across the address step.
                     rom_address <= next_address(rom_address);
                     wait_cnt    <= '0;
                     state       <= WAIT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Directed bench for rom_read_sequencer: a default-parameter instance reading an
// address-echo ROM, and a one-cycle single-address instance.
module tb_rom_read_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   logic       start = 1'b0, abort = 1'b0, data_ready = 1'b0;
   logic [7:0] rom_data;
   logic [8:0] rom_address;
   logic       rom_cs_n, rom_oe_n, data_valid, busy, done;
   logic [7:0] data_out;

   logic       start2 = 1'b0, abort2 = 1'b0, data_ready2 = 1'b0;
   logic [7:0] rom_data2;
   logic [8:0] rom_address2;
   logic       rom_cs_n2, rom_oe_n2, data_valid2, busy2, done2;
   logic [7:0] data_out2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign rom_data  = rom_address[7:0];
   assign rom_data2 = 8'hA5;

   rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(4), .LAST_ADDRESS(511)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .rom_data(rom_data),
      .data_ready(data_ready), .rom_address(rom_address), .rom_cs_n(rom_cs_n),
      .rom_oe_n(rom_oe_n), .data_out(data_out), .data_valid(data_valid),
      .busy(busy), .done(done));

   rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(1), .LAST_ADDRESS(0)) dut1 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort2), .rom_data(rom_data2),
      .data_ready(data_ready2), .rom_address(rom_address2), .rom_cs_n(rom_cs_n2),
      .rom_oe_n(rom_oe_n2), .data_out(data_out2), .data_valid(data_valid2),
      .busy(busy2), .done(done2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_addr(input logic [8:0] a, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (rom_address == a) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; abort = 1'b1; data_ready = 1'b1;
      start2 = 1'b1; abort2 = 1'b1; data_ready2 = 1'b1;
      tick(); tick();
      checks++;
      if ({rom_address, rom_cs_n, rom_oe_n, data_out, data_valid, busy, done} !== {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs: got addr=%0d cs_n=%b oe_n=%b dout=%h dv=%b busy=%b done=%b, want 0 1 1 00 0 0 0",
                  rom_address, rom_cs_n, rom_oe_n, data_out, data_valid, busy, done);
      end
      checks++;
      if ({rom_address2, rom_cs_n2, rom_oe_n2, data_out2, data_valid2, busy2, done2} !== {9'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs_single: got addr=%0d cs_n=%b oe_n=%b dout=%h dv=%b busy=%b done=%b, want 0 1 1 00 0 0 0",
                  rom_address2, rom_cs_n2, rom_oe_n2, data_out2, data_valid2, busy2, done2);
      end
      reset = 1'b0; start = 1'b0; abort = 1'b0; data_ready = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; data_ready2 = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0 || rom_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b cs_n=%b, want 0 1", busy, rom_cs_n);
      end
   endtask

   task automatic test_full_pass();
      int n, first_valid, idx, done_at;
      data_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (rom_cs_n !== 1'b0 || rom_oe_n !== 1'b0 || busy !== 1'b1 || rom_address !== 9'd0) begin
         errors++;
         $display("FAIL pass_start: got cs_n=%b oe_n=%b busy=%b addr=%0d, want 0 0 1 0", rom_cs_n, rom_oe_n, busy, rom_address);
      end
      n = 0; first_valid = -1; idx = 0; done_at = -1;
      for (int i = 0; i < 3000; i++) begin
         tick();
         n++;
         if (data_valid) begin
            if (first_valid < 0) first_valid = n;
            checks++;
            if (data_out !== idx[7:0]) begin
               errors++;
               $display("FAIL pass_byte[%0d]: got %h, want %h", idx, data_out, idx[7:0]);
            end
            idx++;
         end
         if (done) begin
            done_at = n;
            break;
         end
      end
      checks++;
      if (first_valid != 4) begin
         errors++;
         $display("FAIL first_valid_latency: got %0d, want 4", first_valid);
      end
      checks++;
      if (idx != 512) begin
         errors++;
         $display("FAIL byte_count: got %0d, want 512", idx);
      end
      checks++;
      if (done_at != 2560) begin
         errors++;
         $display("FAIL done_latency: got %0d, want 2560", done_at);
      end
      checks++;
      if (busy !== 1'b0 || rom_address !== 9'd511 || rom_cs_n !== 1'b1 || rom_oe_n !== 1'b1) begin
         errors++;
         $display("FAIL pass_end: got busy=%b addr=%0d cs_n=%b oe_n=%b, want 0 511 1 1", busy, rom_address, rom_cs_n, rom_oe_n);
      end
      tick();
      checks++;
      if (done !== 1'b1 || rom_address !== 9'd511) begin
         errors++;
         $display("FAIL done_sticky: got done=%b addr=%0d, want 1 511", done, rom_address);
      end
   endtask

   task automatic test_stall();
      bit ok;
      bit bad;
      data_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_addr(9'd5, ok);
      data_ready = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_reach_addr5: timeout, addr=%0d want 5", rom_address);
      end
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (data_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL stall_valid: timeout, dv=%b want 1", data_valid);
      end
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (data_out !== 8'h05 || data_valid !== 1'b1 || rom_address !== 9'd5) begin
            errors++;
            bad = 1'b1;
            $display("FAIL stall_hold[%0d]: got dout=%h dv=%b addr=%0d, want 05 1 5", i, data_out, data_valid, rom_address);
         end
         if (bad) break;
      end
      data_ready = 1'b1;
      tick();
      checks++;
      if (rom_address !== 9'd6 || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got addr=%0d dv=%b, want 6 0", rom_address, data_valid);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_abort();
      bit ok;
      data_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_addr(9'd100, ok);
      checks++;
      if (!ok || data_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_reach_wait100: got addr=%0d dv=%b, want 100 0", rom_address, data_valid);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({busy, data_valid, rom_cs_n, rom_oe_n, done, rom_address, data_out} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd100, 8'd99}) begin
         errors++;
         $display("FAIL abort_state: got busy=%b dv=%b cs_n=%b oe_n=%b done=%b addr=%0d dout=%h, want 0 0 1 1 0 100 63",
                  busy, data_valid, rom_cs_n, rom_oe_n, done, rom_address, data_out);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || rom_address !== 9'd100 || rom_cs_n !== 1'b1) begin
         errors++;
         $display("FAIL abort_idle_hold: got busy=%b addr=%0d cs_n=%b, want 0 100 1", busy, rom_address, rom_cs_n);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (rom_address !== 9'd0 || busy !== 1'b1 || rom_cs_n !== 1'b0) begin
         errors++;
         $display("FAIL abort_restart: got addr=%0d busy=%b cs_n=%b, want 0 1 0", rom_address, busy, rom_cs_n);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_start_held();
      int n, done_at;
      bit restarted;
      logic [8:0] prev;
      data_ready = 1'b1;
      start = 1'b1;
      tick();
      n = 0; done_at = -1; restarted = 1'b0; prev = rom_address;
      for (int i = 0; i < 3000; i++) begin
         tick();
         n++;
         if (rom_address < prev) restarted = 1'b1;
         prev = rom_address;
         if (done) begin
            done_at = n;
            break;
         end
      end
      checks++;
      if (restarted || done_at != 2560) begin
         errors++;
         $display("FAIL held_start_single_pass: got restarted=%b done_at=%0d, want 0 2560", restarted, done_at);
      end
      tick();
      checks++;
      if (done !== 1'b0 || rom_address !== 9'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL held_start_new_pass: got done=%b addr=%0d busy=%b, want 0 0 1", done, rom_address, busy);
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic test_single_address();
      start2 = 1'b1;
      data_ready2 = 1'b0;
      tick();
      start2 = 1'b0;
      checks++;
      if (busy2 !== 1'b1 || rom_cs_n2 !== 1'b0 || data_valid2 !== 1'b0) begin
         errors++;
         $display("FAIL single_start: got busy=%b cs_n=%b dv=%b, want 1 0 0", busy2, rom_cs_n2, data_valid2);
      end
      tick();
      checks++;
      if (data_valid2 !== 1'b1 || data_out2 !== 8'hA5) begin
         errors++;
         $display("FAIL single_capture: got dv=%b dout=%h, want 1 a5", data_valid2, data_out2);
      end
      tick();
      checks++;
      if (data_valid2 !== 1'b1 || done2 !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: got dv=%b done=%b, want 1 0", data_valid2, done2);
      end
      data_ready2 = 1'b1;
      tick();
      checks++;
      if ({done2, busy2, data_valid2, rom_cs_n2, rom_oe_n2, rom_address2} !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 9'd0}) begin
         errors++;
         $display("FAIL single_done: got done=%b busy=%b dv=%b cs_n=%b oe_n=%b addr=%0d, want 1 0 0 1 1 0",
                  done2, busy2, data_valid2, rom_cs_n2, rom_oe_n2, rom_address2);
      end
      data_ready2 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_stall();
      test_abort();
      test_start_held();
      test_single_address();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rom_read_sequencer.md
Name: rom_read_sequencer

Overview:
- Walks the ROM chip address space from 0 to LAST_ADDRESS, drives address and the chip-select/output-enable strobes, waits the chip access time, and captures each data byte.
- Presents each captured byte on a valid/ready handshake to the downstream data sink.
- Its rom_address output feeds both the ROM chip address pins and the address_display stage, which shows the current address on the seven-segment tubes.

Parameters:
- ADDR_WIDTH, 9, width of rom_address; must match the display stage input width.
- DATA_WIDTH, 8, width of rom_data and data_out.
- ACCESS_CYCLES, 4, clk cycles between address/strobe assertion and data capture; legal range 1..255.
- LAST_ADDRESS, 511, final address read; must be < 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled only in IDLE or DONE; begins a full read pass.
- abort  in  1  synchronous; returns to IDLE from any state.
- rom_data  in  DATA_WIDTH  ROM chip data bus.
- data_ready  in  1  downstream sink accepts data_out this cycle.
- rom_address  out  ADDR_WIDTH  ROM chip address; also drives address_display.address_line.
- rom_cs_n  out  1  ROM chip select, active low.
- rom_oe_n  out  1  ROM output enable, active low.
- data_out  out  DATA_WIDTH  captured byte.
- data_valid  out  1  data_out holds an unaccepted byte.
- busy  out  1  pass in progress.
- done  out  1  pass completed; sticky until next start, abort or reset.

Behaviour:
- Clocking and reset:
  - Reset is the already-decided synchronous, active-high reset on clk.
  - All outputs are registered.
  - Reset values: rom_address=0, rom_cs_n=1, rom_oe_n=1, data_out=0, data_valid=0, busy=0, done=0, wait_cnt=0, state=IDLE.
  - Reset has priority over abort; abort has priority over all other inputs.
- States: IDLE, WAIT, HOLD, DONE.
- IDLE/DONE with start=1, on edge k:
  - rom_address<=0, rom_cs_n<=0, rom_oe_n<=0, busy<=1, done<=0, wait_cnt<=0, state<=WAIT.
- IDLE/DONE with start=0: outputs hold.
  - DONE keeps done=1, strobes high and rom_address=LAST_ADDRESS.
- WAIT:
  - wait_cnt increments each edge.
  - On the edge where wait_cnt==ACCESS_CYCLES-1: data_out<=rom_data, data_valid<=1, state<=HOLD.
  - Capture therefore occurs ACCESS_CYCLES edges after the address changed; data_valid is first visible after edge k+ACCESS_CYCLES.
- HOLD:
  - data_out and data_valid are stable until the edge where data_ready=1.
  - On that edge data_valid<=0, then:
    - if rom_address==LAST_ADDRESS: rom_cs_n<=1, rom_oe_n<=1, busy<=0, done<=1, state<=DONE.
    - else: rom_address<=rom_address+1, wait_cnt<=0, state<=WAIT. Strobes stay low between addresses.
  - data_ready while data_valid=0 is ignored.
- Address handling:
  - rom_address never wraps; the pass ends at LAST_ADDRESS.
  - rom_address changes only on a HOLD handshake, a start, or reset.
- start while busy=1 is ignored; a held start does not restart a pass mid-way.
- abort (any state, busy or not):
  - state<=IDLE, rom_cs_n<=1, rom_oe_n<=1, data_valid<=0, busy<=0, done<=0, wait_cnt<=0.
  - rom_address and data_out hold their last values.
- Single-address pass (LAST_ADDRESS=0): one capture, one handshake, then DONE.
- Back-to-back: with data_ready tied high, each address costs ACCESS_CYCLES+1 cycles (ACCESS_CYCLES in WAIT, 1 in HOLD).
  - A 512-address pass with ACCESS_CYCLES=4 takes 2560 cycles from the start edge to done=1.
- Width rules:
  - wait_cnt is 8 bits.
  - rom_address increment is ADDR_WIDTH wide with no carry out.

Test Plan:
- Reset with start=1, abort=1 and data_ready=1 all asserted -> every output equals its reset value, state IDLE, no strobe activity.
- Default params, rom_data model returns address[7:0], data_ready=1, pulse start -> strobes low 1 cycle after start. Bytes 0x00..0xFF,0x00..0xFF accepted in order. data_valid first high 4 edges after the start edge. done=1 and busy=0 exactly 2560 cycles after the start edge. rom_address=511 at end.
- Stall at address 5: data_ready=0 for 20 cycles -> data_out=0x05 and data_valid stable throughout. rom_address stays 5. Advances to 6 only on the handshake edge.
- start held high for the entire pass -> single pass only; no restart while busy. After DONE with start still high, a new pass begins next edge (done cleared, rom_address=0).
- abort asserted while in WAIT at address 100 -> next cycle IDLE, busy=0, data_valid=0, strobes high, rom_address=100. A following start restarts at address 0.
- ACCESS_CYCLES=1, LAST_ADDRESS=0 -> capture on the edge after start, data_valid high; after one handshake done=1 with strobes high.
